// File: rtl/cout_buffer.sv
// Output-side value FIFO: the CPU loads words from the shared bus, the user pops them with a confirm button.
// Load accepted on the edge after cout_load is seen; cout_done pulses one cycle later; pop lands 2 edges after confirm rises.
// A load while full stalls until a pop frees a slot in the same cycle; the bus is never driven.
module cout_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    inout  tri0  [31:0]                bus,
    input  logic                       cout_load,
    output logic                       cout_done,
    input  logic                       confirm_value,
    output logic [WIDTH-1:0]           value,
    output logic                       value_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DONE     = 2'd1;
    localparam logic [1:0] WAIT_LOW = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ack_d1_q, ack_d1_d;
    logic             ack_d2_q, ack_d2_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic pop_req;
    logic pop;
    logic push;
    logic unused_bus_hi;

    assign bus = 'z;
    assign unused_bus_hi = ^bus[31:WIDTH];

    assign value_valid = (count_q != '0);
    assign full        = (count_q == CW'(DEPTH));
    assign count       = count_q;
    assign value       = value_valid ? mem_q[rd_ptr_q] : '0;
    assign cout_done   = (state_q == DONE);

    // A rising edge while empty is simply dropped.
    assign pop_req = ack_d1_q & ~ack_d2_q;
    assign pop     = pop_req & value_valid;
    assign push    = (state_q == IDLE) & cout_load & (~full | pop);

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ack_d1_d = confirm_value;
        ack_d2_d = ack_d1_q;

        case (state_q)
            IDLE:     if (push) state_d = DONE;
            DONE:     state_d = cout_load ? WAIT_LOW : IDLE;
            WAIT_LOW: if (!cout_load) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ack_d1_q <= 1'b0;
            ack_d2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ack_d1_q <= ack_d1_d;
            ack_d2_q <= ack_d2_d;
        end
    end

    // When full, the write slot equals the head being popped on this same edge.
    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_ptr_q] <= bus[WIDTH-1:0];
    end

endmodule

// File: tb/tb_cout_buffer.sv
// Directed plan steps followed by a randomized load/confirm phase, checked against a queue model.
module tb_cout_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bus_drv;
    wire  [31:0] bus;
    logic        cout_load;
    logic        cout_done;
    logic        confirm_value;
    logic [15:0] value;
    logic        value_valid;
    logic [2:0]  count;
    logic        full;

    int tests = 0;
    int fails = 0;
    logic [15:0] q[$];

    assign bus = bus_drv;

    cout_buffer #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .bus(bus), .cout_load(cout_load),
        .cout_done(cout_done), .confirm_value(confirm_value), .value(value),
        .value_valid(value_valid), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [15:0] hv;
        hv = (q.size() != 0) ? q[0] : 16'h0;
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".value"}, 32'(value), 32'(hv));
        chk({tag, ".valid"}, 32'(value_valid), 32'(q.size() != 0));
        chk({tag, ".full"},  32'(full), 32'(q.size() == 4));
        chk({tag, ".done"},  32'(cout_done), 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [31:0] word);
        logic got;
        got = 1'b0;
        bus_drv   = word;
        cout_load = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            cyc(1);
            if (cout_done) got = 1'b1;
        end
        chk({tag, ".done_seen"}, 32'(got), 32'd1);
        cout_load = 1'b0;
        cyc(2);
        if (got) q.push_back(word[15:0]);
    endtask

    task automatic do_pop();
        confirm_value = 1'b1;
        cyc(4);
        confirm_value = 1'b0;
        cyc(2);
        if (q.size() != 0) void'(q.pop_front());
    endtask

    initial begin
        int pulses;
        int first_at;
        logic got;
        logic [15:0] exp_head;

        reset = 1'b1; bus_drv = 32'h0; cout_load = 1'b0; confirm_value = 1'b0;
        cyc(3);
        chk("reset.count", 32'(count), 32'd0);
        chk("reset.value", 32'(value), 32'd0);
        chk("reset.valid", 32'(value_valid), 32'd0);
        chk("reset.full",  32'(full), 32'd0);
        chk("reset.done",  32'(cout_done), 32'd0);
        reset = 1'b0;
        cyc(1);

        // Plan 1: held load yields one entry and one pulse, one cycle after capture.
        bus_drv = 32'h0000_1234; cout_load = 1'b1;
        pulses = 0; first_at = -1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if (cout_done) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
        chk("p1.pulses", 32'(pulses), 32'd1);
        chk("p1.pulse_cycle", 32'(first_at), 32'd0);
        cout_load = 1'b0;
        cyc(2);
        q.push_back(16'h1234);
        check_state("p1");

        // Plan 2: pop lands on the second edge after confirm rises.
        confirm_value = 1'b1;
        cyc(1);
        chk("p2.edge1_count", 32'(count), 32'd1);
        cyc(1);
        chk("p2.edge2_count", 32'(count), 32'd0);
        void'(q.pop_front());
        cyc(5);
        check_state("p2.hold");
        confirm_value = 1'b0;
        cyc(2);

        // Plan 3: fill, stall, pop-and-push in one cycle, drain in order.
        for (int v = 1; v <= 4; v++) do_load("p3.fill", 32'(v));
        check_state("p3.full");
        bus_drv = 32'd5; cout_load = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (cout_done) got = 1'b1;
        end
        chk("p3.stall_no_done", 32'(got), 32'd0);
        chk("p3.stall_count", 32'(count), 32'd4);
        confirm_value = 1'b1;
        cyc(2);
        chk("p3.swap_done", 32'(cout_done), 32'd1);
        chk("p3.swap_count", 32'(count), 32'd4);
        chk("p3.swap_head", 32'(value), 32'd2);
        cout_load = 1'b0; confirm_value = 1'b0;
        cyc(3);
        void'(q.pop_front());
        q.push_back(16'd5);
        check_state("p3.after_swap");
        for (int v = 2; v <= 5; v++) begin
            chk("p3.drain_head", 32'(value), 32'(v));
            do_pop();
        end
        check_state("p3.empty");

        // Plan 4: confirm while empty is forgotten.
        do_pop();
        do_load("p4", 32'h0000_BEEF);
        check_state("p4");
        do_pop();

        // Plan 5: alternating push/pop across pointer wrap.
        for (int v = 0; v < 10; v++) begin
            do_load("p5", 32'(v));
            chk("p5.head", 32'(value), 32'(v));
            chk("p5.count", 32'(count), 32'd1);
            do_pop();
            check_state("p5.pop");
        end

        // Plan 6: reset during DONE with count=3.
        do_load("p6.a", 32'h11);
        do_load("p6.b", 32'h22);
        bus_drv = 32'h33; cout_load = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            cyc(1);
            if (cout_done) got = 1'b1;
        end
        chk("p6.reached_done", 32'(got), 32'd1);
        chk("p6.count_in_done", 32'(count), 32'd3);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0; cout_load = 1'b0;
        q.delete();
        check_state("p6.after_reset");
        cyc(1);
        check_state("p6.idle");
        do_load("p6.reload", 32'hCAFE_0042);
        check_state("p6.reload");

        // Randomized phase: upper bus bits are noise and must be ignored.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(1) == 1 && q.size() < 4) begin
                do_load("rnd.load", $urandom);
                check_state("rnd.load");
            end else begin
                exp_head = (q.size() != 0) ? q[0] : 16'h0;
                chk("rnd.head", 32'(value), 32'(exp_head));
                do_pop();
                check_state("rnd.pop");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cout_buffer.md
Name: cout_buffer

Overview:
- Output-side counterpart of the user-input register: the CPU writes values from the shared 32-bit bus into a small FIFO.
- The head entry is presented to the user (LEDs/7-seg). The user consumes each value with a confirm button, which pops the FIFO.
- Sits on the shared tri0 bus next to the input register. It is sequenced by the control unit through a load/done handshake.
- It never drives the bus.

Parameters:
- WIDTH, 16, width of stored/displayed value (low bits of bus).
- DEPTH, 4, number of FIFO entries. Must be a power of two, 2..16.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- bus  inout (tri0)  32  shared data bus. Only sampled, never driven (always high-Z from this block).
- cout_load  input  1  control request to capture bus[WIDTH-1:0]. Held high until cout_done is seen.
- cout_done  output  1  one-cycle pulse: request accepted.
- confirm_value  input  1  user acknowledge button, level. Each rising edge pops one entry.
- value  output  WIDTH  head entry of FIFO; 0 when empty.
- value_valid  output  1  FIFO not empty.
- count  output  $clog2(DEPTH+1)  number of stored entries.
- full  output  1  count == DEPTH.

Behaviour:
- Reset (synchronous, active-high; clock clk): the following are all cleared to 0:
  - count, read pointer, write pointer
  - cout_done, value, value_valid, full
  - edge-detect flops
  - load FSM → IDLE
  - Storage contents are don't-care.
  - A reset asserted mid-handshake aborts it: no cout_done pulse, and the entry is lost if not yet written.
- Acknowledge edge detect:
  - Two flops: ack_d1 <= confirm_value; ack_d2 <= ack_d1.
  - pop_req = ack_d1 & ~ack_d2.
  - pop = pop_req & value_valid.
  - A rising edge while empty is discarded; it is not remembered.
  - Latency: the pop takes effect on the 2nd clk edge after confirm_value rises.
- Load FSM (states IDLE, DONE, WAIT_LOW):
  - IDLE:
    - If cout_load & (~full | pop): write bus[WIDTH-1:0] at the write pointer, then go to DONE.
    - Else stay in IDLE. A load while full with no pop stalls with no timeout.
  - DONE:
    - cout_done = 1 for exactly this cycle.
    - If cout_load is still high, go to WAIT_LOW; else go to IDLE.
  - WAIT_LOW: stay until cout_load == 0, then go to IDLE.
  - A cout_load held for many cycles therefore produces exactly one entry and one pulse.
  - cout_done is registered (state-decoded) and goes high the cycle after the write edge.
- FIFO:
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Count update: push only +1; pop only -1; simultaneous push and pop leaves count unchanged. This is legal when full, and also when count==1, where the new entry becomes head after the pop.
  - value = mem[rd_ptr] when count != 0, else 0.
  - value_valid = (count != 0).
  - full = (count == DEPTH).
  - All outputs reflect updated state on the cycle after the edge.
- bus: assign bus = 'z always. Only bus[WIDTH-1:0] is used; upper bits are ignored.

Test Plan:
1. Reset, then cout_load=1 with bus=32'h0000_1234, held 5 cycles → exactly one cout_done pulse one cycle after capture. count=1, value=16'h1234, value_valid=1.
2. Raise confirm_value with one entry (16'h1234) → 2 edges later count=0, value=0, value_valid=0. Holding confirm_value high causes no further pops.
3. Load 1,2,3,4 (each handshake completes) → full=1, count=4. 5th load of 5 stalls, with cout_done low for 20 cycles. Pulse confirm → 5 accepted in the pop cycle, cout_done pulses, count stays 4. Popping four more times yields values 2,3,4,5 in order.
4. Empty FIFO, pulse confirm_value, then load 16'hBEEF → count=1, value=16'hBEEF. The earlier confirm edge was not remembered.
5. Wrap test: push/pop 10 entries alternately with DEPTH=4 (values 0..9) → values pop out in order across pointer wrap; count never exceeds 1.
6. Assert reset for 1 cycle in DONE state with count=3 → next cycle cout_done=0, count=0, value=0, full=0, FSM in IDLE. A subsequent load works normally.
